// File: rtl/cmd_arbiter.sv
// Shares the single cmd_proc command/response path among NUM_REQ command sources:
// one owner at a time, handshakes routed back to the owner only, hung commands aborted.
module cmd_arbiter #(
  parameter int          NUM_REQ = 3,
  parameter bit          PRIO0   = 1'b1,
  parameter logic [23:0] TMO_CYC = 24'd5_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [16*NUM_REQ-1:0] req_cmd_i,
  input  logic [NUM_REQ-1:0]    req_rdy_i,
  input  logic [8*NUM_REQ-1:0]  req_resp_i,
  output logic [NUM_REQ-1:0]    req_clr_o,
  output logic [NUM_REQ-1:0]    req_done_o,
  output logic [15:0]           cmd_o,
  output logic                  cmd_rdy_o,
  input  logic                  clr_cmd_rdy_i,
  input  logic                  send_resp_i,
  output logic [7:0]            resp_o,
  output logic [2:0]            owner_o,
  output logic                  busy_o,
  output logic                  tmo_err_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, EXEC} state_t;

  state_t             state_q;
  logic [15:0]        cmd_q;
  logic [2:0]         owner_q;
  logic [2:0]         rrPtr_q;
  logic [2:0]         rrPtr_d;
  logic               cmdRdy_q;
  logic               busy_q;
  logic [23:0]        timer_q;

  logic [2:0]         winIdx;
  logic [2:0]         lowAny;
  logic [2:0]         lowAbove;
  logic               hitAbove;
  logic [15:0]        winCmd;
  logic [NUM_REQ-1:0] ownerHot;
  logic               clrHit;
  logic               timeout;
  logic               doneHit;

  // Round-robin scan from rrPtr_q: lowest requester at or above the pointer,
  // otherwise wrap to the lowest requester overall.
  always_comb begin
    lowAny   = '0;
    lowAbove = '0;
    hitAbove = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_rdy_i[j[IW-1:0]]) begin
        lowAny = 3'(j);
        if (3'(j) >= rrPtr_q) begin
          lowAbove = 3'(j);
          hitAbove = 1'b1;
        end
      end
    end
    winIdx = hitAbove ? lowAbove : lowAny;
    if (PRIO0 && req_rdy_i[0]) begin
      winIdx = '0;
    end
  end

  always_comb begin
    winCmd = req_cmd_i[15:0];
    for (int j = 0; j < NUM_REQ; j++) begin
      if (winIdx == 3'(j)) begin
        winCmd = req_cmd_i[16*j +: 16];
      end
    end
  end

  always_comb begin
    resp_o = req_resp_i[7:0];
    for (int j = 0; j < NUM_REQ; j++) begin
      if (owner_q == 3'(j)) begin
        resp_o = req_resp_i[8*j +: 8];
      end
    end
  end

  assign ownerHot = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
  assign rrPtr_d  = (owner_q == 3'(NUM_REQ - 1)) ? 3'd0 : owner_q + 3'd1;

  // send_resp at the final timer count still completes normally, without an abort.
  assign clrHit  = (state_q == GRANT) && clr_cmd_rdy_i;
  assign timeout = (state_q == EXEC) && !send_resp_i && (timer_q == TMO_CYC - 24'd1);
  assign doneHit = (state_q == EXEC) && (send_resp_i || timeout);

  assign req_clr_o  = clrHit  ? ownerHot : '0;
  assign req_done_o = doneHit ? ownerHot : '0;
  assign tmo_err_o  = timeout;
  assign cmd_o      = cmd_q;
  assign cmd_rdy_o  = cmdRdy_q;
  assign owner_o    = owner_q;
  assign busy_o     = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cmd_q    <= 16'h0000;
      owner_q  <= 3'd0;
      rrPtr_q  <= 3'd0;
      cmdRdy_q <= 1'b0;
      busy_q   <= 1'b0;
      timer_q  <= 24'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_rdy_i) begin
            state_q  <= GRANT;
            cmd_q    <= winCmd;
            owner_q  <= winIdx;
            cmdRdy_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        GRANT: begin
          if (clr_cmd_rdy_i) begin
            state_q  <= EXEC;
            cmdRdy_q <= 1'b0;
            timer_q  <= 24'd0;
          end
        end
        EXEC: begin
          if (doneHit) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            rrPtr_q <= rrPtr_d;
          end else begin
            timer_q <= timer_q + 24'd1;
          end
        end
        default: begin
          state_q  <= IDLE;
          cmdRdy_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_arbiter.sv
// Bench for cmd_arbiter: a round-robin instance (index 0) and a UART-priority
// instance (index 1), both with a 16-cycle timeout, checked against a transaction model.
module tb_cmd_arbiter;

  localparam int NR      = 3;
  localparam int TMO_INT = 16;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [47:0] reqCmd    [2];
  logic [2:0]  reqRdy    [2];
  logic [23:0] reqResp   [2];
  logic        clrCmdRdy [2];
  logic        sendResp  [2];
  logic [2:0]  reqClr    [2];
  logic [2:0]  reqDone   [2];
  logic [15:0] cmdOut    [2];
  logic        cmdRdy    [2];
  logic [7:0]  respOut   [2];
  logic [2:0]  ownerOut  [2];
  logic        busyOut   [2];
  logic        tmoErr    [2];

  logic [15:0] srcCmd  [2][NR];
  logic [7:0]  srcResp [2][NR];

  int vectors     = 0;
  int miscompares = 0;
  int rrModel [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gSrc
    assign reqCmd[g]  = {srcCmd[g][2], srcCmd[g][1], srcCmd[g][0]};
    assign reqResp[g] = {srcResp[g][2], srcResp[g][1], srcResp[g][0]};
  end

  cmd_arbiter #(.NUM_REQ(NR), .PRIO0(1'b0), .TMO_CYC(24'(TMO_INT))) dutRr (
    .clk(clk), .rst_n(rst_n),
    .req_cmd_i(reqCmd[0]), .req_rdy_i(reqRdy[0]), .req_resp_i(reqResp[0]),
    .req_clr_o(reqClr[0]), .req_done_o(reqDone[0]),
    .cmd_o(cmdOut[0]), .cmd_rdy_o(cmdRdy[0]),
    .clr_cmd_rdy_i(clrCmdRdy[0]), .send_resp_i(sendResp[0]),
    .resp_o(respOut[0]), .owner_o(ownerOut[0]), .busy_o(busyOut[0]), .tmo_err_o(tmoErr[0])
  );

  cmd_arbiter #(.NUM_REQ(NR), .PRIO0(1'b1), .TMO_CYC(24'(TMO_INT))) dutPrio (
    .clk(clk), .rst_n(rst_n),
    .req_cmd_i(reqCmd[1]), .req_rdy_i(reqRdy[1]), .req_resp_i(reqResp[1]),
    .req_clr_o(reqClr[1]), .req_done_o(reqDone[1]),
    .cmd_o(cmdOut[1]), .cmd_rdy_o(cmdRdy[1]),
    .clr_cmd_rdy_i(clrCmdRdy[1]), .send_resp_i(sendResp[1]),
    .resp_o(respOut[1]), .owner_o(ownerOut[1]), .busy_o(busyOut[1]), .tmo_err_o(tmoErr[1])
  );

  // Reference arbitration rule: UART first on the priority instance, otherwise
  // the first requester found scanning upward from the pointer, modulo NR.
  function automatic int pickWinner(input int d, input int rr, input logic [2:0] rdy);
    int c;
    if (d == 1 && rdy[0]) return 0;
    for (int k = 0; k < NR; k++) begin
      c = (rr + k) % NR;
      if (rdy[c]) return c;
    end
    return 0;
  endfunction

  task automatic applyStimulus(input int d);
    for (int k = 0; k < NR; k++) begin
      srcCmd[d][k]  = 16'($urandom);
      srcResp[d][k] = 8'($urandom);
    end
  endtask

  task automatic idleInputs();
    for (int d = 0; d < 2; d++) begin
      reqRdy[d]    = 3'b000;
      clrCmdRdy[d] = 1'b0;
      sendResp[d]  = 1'b0;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    idleInputs();
    rrModel[0] = 0;
    rrModel[1] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Plays cmd_proc for one command on instance d; execCycles < 0 means never respond.
  task automatic runTransaction(input int d, input int execCycles, input bit dropOnClr,
                                input logic [2:0] addInExec, output int gotOwner);
    int          expOwner;
    logic [15:0] expCmd;
    logic [2:0]  expHot;
    logic        expTmo;
    int          grantWait;
    expOwner  = pickWinner(d, rrModel[d], reqRdy[d]);
    expCmd    = srcCmd[d][expOwner];
    expHot    = 3'b001 << expOwner;
    expTmo    = (execCycles < 0);
    @(negedge clk); #1;
    vectors++;
    if (cmdRdy[d] !== 1'b1 || busyOut[d] !== 1'b1)
      $display("[TB] FAIL grant_latency dut%0d: cmd_rdy=%b busy=%b, expected 1 1", d, cmdRdy[d], busyOut[d]);
    vectors++;
    if (cmdOut[d] !== expCmd || ownerOut[d] !== 3'(expOwner)) begin
      miscompares++;
      $display("[TB] FAIL grant_cmd dut%0d: cmd=%h owner=%0d, expected cmd=%h owner=%0d",
               d, cmdOut[d], ownerOut[d], expCmd, expOwner);
    end
    if (cmdRdy[d] !== 1'b1 || busyOut[d] !== 1'b1) miscompares++;
    gotOwner  = int'(ownerOut[d]);
    grantWait = $urandom_range(0, 2);
    for (int i = 0; i < grantWait; i++) begin
      @(negedge clk);
      applyStimulus(d);
      sendResp[d] = (i == 0);
      #1;
      vectors++;
      if (cmdRdy[d] !== 1'b1 || cmdOut[d] !== expCmd || reqDone[d] !== 3'b000 || reqClr[d] !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL grant_hold dut%0d: cmd_rdy=%b cmd=%h done=%b clr=%b, expected 1 %h 000 000",
                 d, cmdRdy[d], cmdOut[d], reqDone[d], reqClr[d], expCmd);
      end
    end
    @(negedge clk);
    clrCmdRdy[d] = 1'b1;
    sendResp[d]  = 1'($urandom_range(0, 1));
    #1;
    vectors++;
    if (reqClr[d] !== expHot || reqDone[d] !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL clr_route dut%0d: clr=%b done=%b, expected clr=%b done=000",
               d, reqClr[d], reqDone[d], expHot);
    end
    @(negedge clk);
    clrCmdRdy[d] = 1'b0;
    sendResp[d]  = 1'b0;
    if (dropOnClr) reqRdy[d][expOwner] = 1'b0;
    for (int c = 0; c < TMO_INT; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) reqRdy[d] = reqRdy[d] | addInExec;
      sendResp[d]  = (c == execCycles);
      clrCmdRdy[d] = (c == 2);
      #1;
      if (c == execCycles || (expTmo && c == TMO_INT - 1)) begin
        vectors++;
        if (reqDone[d] !== expHot || respOut[d] !== srcResp[d][expOwner] || tmoErr[d] !== expTmo) begin
          miscompares++;
          $display("[TB] FAIL done_route dut%0d cyc%0d: done=%b resp=%h tmo=%b, expected done=%b resp=%h tmo=%b",
                   d, c, reqDone[d], respOut[d], tmoErr[d], expHot, srcResp[d][expOwner], expTmo);
        end
        break;
      end else begin
        vectors++;
        if (cmdRdy[d] !== 1'b0 || busyOut[d] !== 1'b1 || reqDone[d] !== 3'b000 ||
            reqClr[d] !== 3'b000 || tmoErr[d] !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL exec_hold dut%0d cyc%0d: cmd_rdy=%b busy=%b done=%b clr=%b tmo=%b, expected 0 1 000 000 0",
                   d, c, cmdRdy[d], busyOut[d], reqDone[d], reqClr[d], tmoErr[d]);
        end
      end
    end
    rrModel[d] = (expOwner + 1) % NR;
    @(negedge clk);
    sendResp[d]  = 1'b0;
    clrCmdRdy[d] = 1'b0;
    #1;
    vectors++;
    if (busyOut[d] !== 1'b0 || cmdRdy[d] !== 1'b0 || reqDone[d] !== 3'b000 || tmoErr[d] !== 1'b0 ||
        ownerOut[d] !== 3'(expOwner) || respOut[d] !== srcResp[d][expOwner]) begin
      miscompares++;
      $display("[TB] FAIL idle_return dut%0d: busy=%b cmd_rdy=%b done=%b tmo=%b owner=%0d resp=%h, expected 0 0 000 0 %0d %h",
               d, busyOut[d], cmdRdy[d], reqDone[d], tmoErr[d], ownerOut[d], respOut[d],
               expOwner, srcResp[d][expOwner]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(0);
    applyStimulus(1);
    for (int d = 0; d < 2; d++) begin
      reqRdy[d]    = 3'b111;
      clrCmdRdy[d] = 1'b1;
      sendResp[d]  = 1'b1;
    end
    rrModel[0] = 0;
    rrModel[1] = 0;
    repeat (2) begin
      @(negedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (cmdRdy[d] !== 1'b0 || busyOut[d] !== 1'b0 || cmdOut[d] !== 16'h0000 || ownerOut[d] !== 3'd0 ||
            reqClr[d] !== 3'b000 || reqDone[d] !== 3'b000 || tmoErr[d] !== 1'b0 || respOut[d] !== srcResp[d][0]) begin
          miscompares++;
          $display("[TB] FAIL reset_state dut%0d: cmd_rdy=%b busy=%b cmd=%h owner=%0d clr=%b done=%b tmo=%b resp=%h, expected 0 0 0000 0 000 000 0 %h",
                   d, cmdRdy[d], busyOut[d], cmdOut[d], ownerOut[d], reqClr[d], reqDone[d], tmoErr[d],
                   respOut[d], srcResp[d][0]);
        end
      end
    end
    @(negedge clk);
    idleInputs();
    rst_n = 1'b1;
    @(negedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (busyOut[d] !== 1'b0 || cmdRdy[d] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_idle dut%0d: busy=%b cmd_rdy=%b, expected 0 0", d, busyOut[d], cmdRdy[d]);
      end
    end
  endtask

  task automatic test_single();
    int o;
    for (int d = 0; d < 2; d++) begin
      applyStimulus(d);
      srcCmd[d][1]  = 16'h2BF1;
      srcResp[d][1] = 8'h5A;
      reqRdy[d]     = 3'b010;
      runTransaction(d, 3, 1'b1, 3'b000, o);
      reqRdy[d] = 3'b000;
    end
  endtask

  task automatic test_round_robin();
    int o;
    int expRr [4] = '{0, 1, 2, 0};
    int expPr [4] = '{0, 0, 0, 0};
    doReset();
    for (int d = 0; d < 2; d++) begin
      reqRdy[d] = 3'b111;
      for (int i = 0; i < 4; i++) begin
        applyStimulus(d);
        runTransaction(d, $urandom_range(0, 4), 1'b0, 3'b000, o);
        vectors++;
        if (o !== ((d == 0) ? expRr[i] : expPr[i])) begin
          miscompares++;
          $display("[TB] FAIL rr_order dut%0d step%0d: owner=%0d, expected %0d",
                   d, i, o, (d == 0) ? expRr[i] : expPr[i]);
        end
      end
      reqRdy[d] = 3'b000;
    end
  endtask

  task automatic test_no_preempt();
    int o;
    int expRr [3] = '{1, 2, 0};
    int expPr [3] = '{1, 0, 2};
    doReset();
    for (int d = 0; d < 2; d++) begin
      reqRdy[d] = 3'b010;
      for (int i = 0; i < 3; i++) begin
        applyStimulus(d);
        runTransaction(d, 5, 1'b1, (i == 0) ? 3'b101 : 3'b000, o);
        vectors++;
        if (o !== ((d == 0) ? expRr[i] : expPr[i])) begin
          miscompares++;
          $display("[TB] FAIL preempt_order dut%0d step%0d: owner=%0d, expected %0d",
                   d, i, o, (d == 0) ? expRr[i] : expPr[i]);
        end
      end
      reqRdy[d] = 3'b000;
    end
  endtask

  task automatic test_timeout();
    int o;
    for (int d = 0; d < 2; d++) begin
      applyStimulus(d);
      reqRdy[d] = 3'($urandom_range(1, 7));
      runTransaction(d, -1, 1'b1, 3'b000, o);
      applyStimulus(d);
      reqRdy[d] = 3'($urandom_range(1, 7));
      runTransaction(d, TMO_INT - 1, 1'b1, 3'b000, o);
      applyStimulus(d);
      reqRdy[d] = 3'($urandom_range(1, 7));
      runTransaction(d, 0, 1'b1, 3'b000, o);
      reqRdy[d] = 3'b000;
    end
  endtask

  task automatic test_async_reset();
    int o;
    applyStimulus(0);
    @(negedge clk);
    reqRdy[0] = 3'b100;
    @(negedge clk);
    clrCmdRdy[0] = 1'b1;
    @(negedge clk);
    clrCmdRdy[0] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (cmdRdy[0] !== 1'b0 || busyOut[0] !== 1'b0 || reqDone[0] !== 3'b000 || reqClr[0] !== 3'b000 ||
        ownerOut[0] !== 3'd0 || cmdOut[0] !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL async_reset: cmd_rdy=%b busy=%b done=%b clr=%b owner=%0d cmd=%h, expected 0 0 000 000 0 0000",
               cmdRdy[0], busyOut[0], reqDone[0], reqClr[0], ownerOut[0], cmdOut[0]);
    end
    @(negedge clk);
    idleInputs();
    rrModel[0] = 0;
    rrModel[1] = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sendResp[0]  = 1'b1;
      clrCmdRdy[0] = (i == 1);
      #1;
      vectors++;
      if (reqDone[0] !== 3'b000 || reqClr[0] !== 3'b000 || busyOut[0] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stray_resp cyc%0d: done=%b clr=%b busy=%b, expected 000 000 0",
                 i, reqDone[0], reqClr[0], busyOut[0]);
      end
    end
    @(negedge clk);
    sendResp[0]  = 1'b0;
    clrCmdRdy[0] = 1'b0;
    reqRdy[0]    = 3'b100;
    runTransaction(0, 2, 1'b1, 3'b000, o);
    reqRdy[0] = 3'b000;
  endtask

  task automatic test_random();
    int o;
    int ex;
    for (int n = 0; n < 25; n++) begin
      for (int d = 0; d < 2; d++) begin
        applyStimulus(d);
        reqRdy[d] = 3'($urandom_range(1, 7));
        ex = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 12);
        runTransaction(d, ex, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), o);
        reqRdy[d] = 3'b000;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idleInputs();
    test_reset();
    test_single();
    test_round_robin();
    test_no_preempt();
    test_timeout();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
